// File: rtl/tpx3_rx_lane_arbiter_pkg.sv
// tpx3_rx_arb_pkg: shared defaults and FSM state type for the Timepix3 lane arbiter
package tpx3_rx_arb_pkg;
   localparam int NUM_LANES_DEF = 8;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int MAX_BURST_DEF = 16;
   localparam int LANE_W = $clog2(NUM_LANES_DEF);
   typedef enum logic {IDLE, BURST} state_t;
endpackage

// File: rtl/tpx3_rx_lane_arbiter_rr_pick.sv
// rr_pick: round-robin priority encoder, first request above last, wrapping
module rr_pick import tpx3_rx_arb_pkg::*; #(
   parameter int NUM_LANES = NUM_LANES_DEF,
   parameter int LW = $clog2(NUM_LANES)
) (
   input  logic [NUM_LANES-1:0] req,
   input  logic [LW-1:0]        last,
   output logic                 any,
   output logic [LW-1:0]        idx
);
   logic [LW-1:0] cand;
   always_comb begin
      any = |req;
      idx = '0;
      cand = '0;
      for (int k = NUM_LANES; k >= 1; k--) begin
         cand = last + LW'(k);
         if (req[cand]) idx = cand;
      end
   end
endmodule

// File: rtl/tpx3_rx_lane_arbiter.sv
// tpx3_rx_lane_arbiter: merges receiver lane streams into one tagged stream with bounded round-robin bursts
module tpx3_rx_lane_arbiter import tpx3_rx_arb_pkg::*; #(
   parameter int NUM_LANES = NUM_LANES_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF,
   localparam int LW = $clog2(NUM_LANES)
) (
   input  logic                            BUS_CLK,
   input  logic                            BUS_RST,
   input  logic [NUM_LANES-1:0]            LANE_ENABLE,
   input  logic [NUM_LANES-1:0]            RX_READY,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] IN_DATA,
   input  logic [NUM_LANES-1:0]            IN_VALID,
   output logic [NUM_LANES-1:0]            IN_READY,
   output logic [DATA_WIDTH-1:0]           OUT_DATA,
   output logic [LW-1:0]                   OUT_LANE,
   output logic                            OUT_VALID,
   input  logic                            OUT_READY,
   output logic                            BUSY,
   output logic [15:0]                     GRANT_COUNT
);
   localparam int BW = $clog2(MAX_BURST + 1);
   state_t state, state_nxt;
   logic [LW-1:0] grant, last_grant, pick;
   logic [BW-1:0] burst_cnt;
   logic [NUM_LANES-1:0] elig;
   logic any, xfer, last_word;
   assign elig = LANE_ENABLE & RX_READY & IN_VALID;
   rr_pick #(.NUM_LANES(NUM_LANES), .LW(LW)) u_pick (
      .req(elig),
      .last(last_grant),
      .any(any),
      .idx(pick)
   );
   // handshake depends only on registered state and lane status, never on IN_DATA
   always_comb begin
      xfer = state == BURST && elig[grant] && (!OUT_VALID || OUT_READY);
      last_word = burst_cnt == BW'(MAX_BURST - 1);
      IN_READY = xfer ? NUM_LANES'(1) << grant : '0;
      BUSY = state == BURST;
      state_nxt = state == IDLE ? (any ? BURST : IDLE)
                : (!elig[grant] || (xfer && last_word)) ? IDLE : BURST;
   end
   always_ff @(posedge BUS_CLK)
      state <= BUS_RST ? IDLE : state_nxt;
   always_ff @(posedge BUS_CLK)
      if (BUS_RST) begin
         grant <= '0;
         last_grant <= LW'(NUM_LANES - 1);
         burst_cnt <= '0;
         GRANT_COUNT <= '0;
         OUT_DATA <= '0;
         OUT_LANE <= '0;
         OUT_VALID <= 1'b0;
      end else begin
         if (state == IDLE && any) begin
            grant <= pick;
            last_grant <= pick;
            burst_cnt <= '0;
            GRANT_COUNT <= GRANT_COUNT + 16'd1;
         end
         if (xfer) begin
            OUT_DATA <= IN_DATA[grant*DATA_WIDTH +: DATA_WIDTH];
            OUT_LANE <= grant;
            OUT_VALID <= 1'b1;
            burst_cnt <= burst_cnt + BW'(1);
         end else if (OUT_READY) OUT_VALID <= 1'b0;
      end
endmodule

// File: tb/tb_tpx3_rx_lane_arbiter.sv
// tb_tpx3_rx_lane_arbiter: scoreboard bench, lane sources carry {lane, sequence} words
module tb_tpx3_rx_lane_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic [7:0] lane_enable, rx_ready, in_valid, in_ready;
   logic [255:0] in_data;
   logic [31:0] out_data;
   logic [2:0] out_lane;
   logic out_valid, out_ready, busy;
   logic [15:0] grant_count;
   int seq[8];
   int avail[8];
   logic [34:0] q[$];
   int errors = 0, checks = 0, pops = 0, idle_cnt = 0, viol = 0;
   logic [15:0] gc_s;
   logic busy_s;
   always #5 clk = ~clk;
   tpx3_rx_lane_arbiter dut (
      .BUS_CLK(clk),
      .BUS_RST(rst),
      .LANE_ENABLE(lane_enable),
      .RX_READY(rx_ready),
      .IN_DATA(in_data),
      .IN_VALID(in_valid),
      .IN_READY(in_ready),
      .OUT_DATA(out_data),
      .OUT_LANE(out_lane),
      .OUT_VALID(out_valid),
      .OUT_READY(out_ready),
      .BUSY(busy),
      .GRANT_COUNT(grant_count)
   );
   function automatic logic [31:0] mk_word(int l, int s);
      return {8'(l), 24'(s)};
   endfunction
   task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic drive_src();
      for (int i = 0; i < 8; i++) begin
         in_valid[i] = avail[i] > 0;
         in_data[i*32 +: 32] = mk_word(i, seq[i]);
      end
   endtask
   task automatic push_words(int l, int s0, int n);
      for (int k = 0; k < n; k++) q.push_back({3'(l), mk_word(l, s0 + k)});
   endtask
   // one clock: sample at negedge, advance sources just after posedge
   task automatic step();
      logic [7:0] take;
      logic [34:0] exp;
      @(negedge clk);
      take = in_ready;
      gc_s = grant_count;
      busy_s = busy;
      if ((in_ready & ~(lane_enable & rx_ready)) != 8'd0 || $countones(in_ready) > 1) viol++;
      if (out_valid && out_ready) begin
         exp = (q.size() > 0) ? q.pop_front() : '1;
         chk("out_word", 64'({out_lane, out_data}), 64'(exp));
         pops++;
      end else if (pops > 0 && !out_valid) idle_cnt++;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++)
         if (take[i] === 1'b1) begin
            seq[i]++;
            avail[i]--;
         end
      drive_src();
   endtask
   task automatic run_pops(int n);
      int c = 0;
      while (pops < n && c < 2000) begin
         step();
         c++;
      end
      chk("pop_count", 64'(pops), 64'(n));
      out_ready = 1'b0;
   endtask
   task automatic do_reset();
      out_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      q.delete();
      pops = 0;
      idle_cnt = 0;
      viol = 0;
      for (int i = 0; i < 8; i++) begin
         seq[i] = 0;
         avail[i] = 0;
      end
      drive_src();
   endtask
   initial begin
      int c;
      rst = 1'b1;
      lane_enable = '0;
      rx_ready = '0;
      out_ready = 1'b0;
      in_valid = '0;
      in_data = '0;
      for (int i = 0; i < 8; i++) begin
         seq[i] = 0;
         avail[i] = 0;
      end
      step();
      step();
      rst = 1'b0;
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_gcount", 64'(grant_count), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_data", 64'({out_lane, out_data}), 64'(0));
      // all lanes streaming: lanes 0..7 then lane 0 again, 16 words each
      lane_enable = 8'hFF;
      rx_ready = 8'hFF;
      for (int i = 0; i < 8; i++) avail[i] = 1000;
      drive_src();
      for (int b = 0; b < 9; b++) push_words(b % 8, (b / 8) * 16, 16);
      out_ready = 1'b1;
      run_pops(144);
      chk("s1_gaps", 64'(idle_cnt), 64'(8));
      chk("s1_gcount", 64'(gc_s), 64'(9));
      chk("s1_q_empty", 64'(q.size()), 64'(0));
      chk("s1_viol", 64'(viol), 64'(0));
      // lane 5 alone with 40 words
      do_reset();
      avail[5] = 40;
      drive_src();
      push_words(5, 0, 40);
      out_ready = 1'b1;
      run_pops(40);
      chk("s2_gaps", 64'(idle_cnt), 64'(2));
      out_ready = 1'b1;
      step();
      step();
      step();
      chk("s2_gcount", 64'(gc_s), 64'(3));
      chk("s2_busy", 64'(busy_s), 64'(0));
      chk("s2_q_empty", 64'(q.size()), 64'(0));
      // lane 3 with a 10-cycle downstream stall
      do_reset();
      avail[3] = 20;
      drive_src();
      push_words(3, 0, 20);
      out_ready = 1'b1;
      run_pops(3);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("s3_hold_word", 64'({out_lane, out_data}), 64'(q[0]));
         chk("s3_hold_ready", 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
      run_pops(20);
      chk("s3_q_empty", 64'(q.size()), 64'(0));
      // disable lane 2 after its 4th accepted word; lane 4 carries on
      do_reset();
      avail[2] = 100;
      avail[4] = 100;
      drive_src();
      push_words(2, 0, 4);
      push_words(4, 0, 32);
      out_ready = 1'b1;
      c = 0;
      while (seq[2] < 4 && c < 200) begin
         step();
         c++;
      end
      chk("s4_took4", 64'(seq[2]), 64'(4));
      lane_enable[2] = 1'b0;
      step();
      step();
      chk("s4_idle", 64'(busy_s), 64'(0));
      run_pops(36);
      chk("s4_no_5th", 64'(seq[2]), 64'(4));
      chk("s4_viol", 64'(viol), 64'(0));
      chk("s4_q_empty", 64'(q.size()), 64'(0));
      lane_enable = 8'hFF;
      // lane 6 valid but its receiver not ready
      do_reset();
      rx_ready = 8'hBF;
      avail[6] = 100;
      avail[7] = 100;
      drive_src();
      push_words(7, 0, 40);
      out_ready = 1'b1;
      run_pops(40);
      chk("s5_lane6_untaken", 64'(seq[6]), 64'(0));
      chk("s5_viol", 64'(viol), 64'(0));
      chk("s5_q_empty", 64'(q.size()), 64'(0));
      rx_ready = 8'hFF;
      // reset mid-burst with a word pending in the output register
      do_reset();
      avail[3] = 100;
      drive_src();
      push_words(3, 0, 5);
      out_ready = 1'b1;
      run_pops(5);
      step();
      chk("s6_pending", 64'({busy, out_valid}), 64'(3));
      avail[0] = 100;
      drive_src();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("s6_valid", 64'(out_valid), 64'(0));
      chk("s6_busy", 64'(busy), 64'(0));
      chk("s6_gcount", 64'(grant_count), 64'(0));
      chk("s6_in_ready", 64'(in_ready), 64'(0));
      q.delete();
      pops = 0;
      push_words(0, 0, 16);
      push_words(3, seq[3], 16);
      out_ready = 1'b1;
      run_pops(32);
      chk("s6_q_empty", 64'(q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tpx3_rx_lane_arbiter.md
Name: tpx3_rx_lane_arbiter

Overview:
Round-robin arbiter that merges the eight Timepix3 receiver lane output streams into the single 32-bit stream feeding the SFP/Ethernet readout FIFO. A lane is eligible only when software has enabled it and its receiver reports RX_READY. Each grant carries a bounded burst so no lane can starve the others. Every output word is tagged with its source lane.

Parameters:
NUM_LANES, 8, number of receiver lanes (power of two, 2..8)
DATA_WIDTH, 32, word width per lane
MAX_BURST, 16, maximum words transferred per grant (1..256)

Ports:
BUS_CLK  in  1  system clock; all logic on rising edge
BUS_RST  in  1  synchronous reset, active-high
LANE_ENABLE  in  NUM_LANES  software lane enable mask
RX_READY  in  NUM_LANES  per-lane receiver locked/aligned
IN_DATA  in  NUM_LANES*DATA_WIDTH  lane words, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
IN_VALID  in  NUM_LANES  lane word available
IN_READY  out  NUM_LANES  word consumed this cycle (one-hot or zero)
OUT_DATA  out  DATA_WIDTH  merged word
OUT_LANE  out  clog2(NUM_LANES)  source lane of OUT_DATA
OUT_VALID  out  1  OUT_DATA valid
OUT_READY  in  1  downstream accepts
BUSY  out  1  high while state is BURST
GRANT_COUNT  out  16  number of grants issued, wraps

Behaviour:
- Eligible vector: elig[i] = LANE_ENABLE[i] & RX_READY[i] & IN_VALID[i].
- FSM has two states, IDLE and BURST.
- IDLE:
  - If elig is non-zero, pick the first set bit searching from last_grant+1 upward, wrapping modulo NUM_LANES.
  - Store the pick in grant, set last_grant=grant, clear burst_cnt, increment GRANT_COUNT, go to BURST.
  - No transfers occur in IDLE, so each grant costs a 1-cycle arbitration bubble.
- BURST:
  - Define can_load = !OUT_VALID | OUT_READY.
  - IN_READY[grant] = elig[grant] & can_load. All other IN_READY bits are 0.
  - IN_READY is combinational from registered state and inputs, with no path from IN_DATA.
  - On a transfer, OUT_DATA<=IN_DATA[grant], OUT_LANE<=grant, OUT_VALID<=1, burst_cnt++.
  - Latency is 1 cycle, from the accepting edge to OUT_VALID.
  - Leave BURST for IDLE at the edge where any of these holds:
    - a transfer occurs and burst_cnt reaches MAX_BURST;
    - elig[grant]==0 (valid dropped, lane disabled, or RX_READY lost).
  - A word already in the output register is still delivered after the lane is disabled or loses RX_READY.
- Output register:
  - OUT_VALID clears when OUT_READY=1 and no new word loads in the same cycle.
  - While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_LANE stay stable and IN_READY is all 0.
  - Full throughput is 1 word/cycle within a burst while OUT_READY=1.
- Simultaneous events:
  - Downstream pop and new load in the same cycle: the load wins, OUT_VALID stays 1.
  - If several lanes become eligible together, the round-robin order decides.
  - A lane that just finished its burst has lowest priority at the next pick.
- Reset takes effect at the next edge, including mid-burst. Reset values:
  - OUT_VALID=0, OUT_DATA=0, OUT_LANE=0, BUSY=0, GRANT_COUNT=0, IN_READY=0;
  - state=IDLE, last_grant=NUM_LANES-1, so lane 0 wins first.
  - A word pending in the output register is discarded.
- Width rules:
  - burst_cnt is clog2(MAX_BURST+1) bits.
  - GRANT_COUNT wraps 0xFFFF->0x0000 silently.

Decomposition:
- Package tpx3_rx_arb_pkg holds:
  - LANE_W = clog2(NUM_LANES);
  - the state enum {IDLE, BURST};
  - default constants for NUM_LANES, DATA_WIDTH and MAX_BURST.
- One sub-module, rr_pick: combinational round-robin priority encoder.
  - Inputs: req[NUM_LANES], last[LANE_W].
  - Outputs: any, idx[LANE_W].
  - Reused by other arbiters in the readout path.

Test Plan:
- Reset, then all 8 lanes enabled, ready and continuously valid, OUT_READY=1, MAX_BURST=16 -> OUT_LANE sequence 0,1,...,7,0; each lane yields exactly 16 consecutive words followed by a 1-cycle gap; GRANT_COUNT=9 after the 9th grant.
- Only lane 5 has data, and lane 5 has 40 words -> bursts of 16, 16 and 8 words, all OUT_LANE=5, with a 1-cycle bubble between bursts.
- Lane 3 is granted and OUT_READY is held 0 for 10 cycles -> OUT_DATA and OUT_LANE are stable, IN_READY=0; after release, transfers resume with no lost or duplicated words (verified with per-lane sequence numbers).
- Clear LANE_ENABLE[2] mid-burst, after 4 words accepted -> the 4th word is still output, no 5th word is taken, the FSM returns to IDLE and lane 2 is never granted again while disabled.
- RX_READY[6]=0 with IN_VALID[6]=1 and LANE_ENABLE=0xFF -> lane 6 is never granted and IN_READY[6] stays 0.
- Assert BUS_RST for 1 cycle mid-burst with OUT_VALID=1 -> at the next edge OUT_VALID=0, BUSY=0, GRANT_COUNT=0; the first grant after reset goes to lane 0 if eligible.
